trace_packer: RTL and testbench

Multi-channel trace collector for emulation designs: up to CH_NUM independent trace sources, each with a small per-channel FIFO, round-robin arbitrated into a single registered valid/ready stream for one downstream data sink. Each output word is tagged with its channel ID and, optionally, a capture timestamp. Sources never see back-pressure; overflow drops the sample and counts it. Sits between user trace points and the sink.

---
 rtl/trace_packer_pkg.sv | 24 ++
 rtl/trace_packer_if.sv | 30 +++
 rtl/trace_fifo.sv | 51 +++++
 rtl/trace_packer.sv | 119 +++++++++++
 tb/tb_trace_packer.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/trace_packer_pkg.sv
// Shared constants and width helpers for the trace_packer block.
// TRACE_PACKER_TIMESTAMP_EN adds a capture timestamp to every output word.
package trace_packer_pkg;

    localparam int unsigned DROP_CNT_W = 16;
    localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = 16'hFFFF;

`ifdef TRACE_PACKER_TIMESTAMP_EN
    localparam bit TS_EN = 1'b1;
`else
    localparam bit TS_EN = 1'b0;
`endif

    function automatic int unsigned calc_ch_w(input int unsigned ch_num);
        return (ch_num <= 1) ? 1 : $clog2(ch_num);
    endfunction

    function automatic int unsigned calc_out_width(input int unsigned ch_num,
                                                   input int unsigned data_width,
                                                   input int unsigned ts_width);
        return (TS_EN ? ts_width : 0) + calc_ch_w(ch_num) + data_width;
    endfunction

endpackage

// File: rtl/trace_packer_if.sv
// Trace sources in, packed valid/ready stream out, plus drop status.
// The master side is the packer, the slave side is the surrounding design.
interface trace_packer_if
    import trace_packer_pkg::*;
#(
    parameter int unsigned CH_NUM     = 4,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned TS_WIDTH   = 32
);
    localparam int unsigned OUT_WIDTH = calc_out_width(CH_NUM, DATA_WIDTH, TS_WIDTH);

    logic [CH_NUM-1:0]            in_valid;
    logic [CH_NUM*DATA_WIDTH-1:0] in_data;
    logic                         out_valid;
    logic                         out_ready;
    logic [OUT_WIDTH-1:0]         out_data;
    logic [CH_NUM-1:0]            overflow;
    logic [CH_NUM*DROP_CNT_W-1:0] drop_cnt;

    modport master (
        input  in_valid, in_data, out_ready,
        output out_valid, out_data, overflow, drop_cnt
    );

    modport slave (
        output in_valid, in_data, out_ready,
        input  out_valid, out_data, overflow, drop_cnt
    );

endinterface

// File: rtl/trace_fifo.sv
// Single-clock FIFO with async reset; full is based on start-of-cycle occupancy,
// so a same-cycle pop never makes room for a same-cycle push.
module trace_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wdata,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_wr, do_rd;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;
    assign rdata = mem[rd_ptr_q];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage is not reset; validity is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/trace_packer.sv
// Multi-channel trace collector: per-channel FIFOs, round-robin into one registered stream.
// Define TRACE_PACKER_TIMESTAMP_EN to stamp each sample with a free-running capture counter.
module trace_packer
    import trace_packer_pkg::*;
#(
    parameter int unsigned CH_NUM     = 4,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned TS_WIDTH   = 32
) (
    input logic            clk,
    input logic            rst,
    trace_packer_if.master bus
);
    localparam int unsigned CH_W      = calc_ch_w(CH_NUM);
    localparam int unsigned OUT_WIDTH = calc_out_width(CH_NUM, DATA_WIDTH, TS_WIDTH);

`ifdef TRACE_PACKER_TIMESTAMP_EN
    localparam int unsigned ENTRY_W = TS_WIDTH + DATA_WIDTH;

    logic [TS_WIDTH-1:0] ts_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ts_q <= '0;
        else     ts_q <= ts_q + 1'b1;
    end
`else
    localparam int unsigned ENTRY_W = DATA_WIDTH;
`endif

    logic [CH_NUM-1:0]    fifo_full, fifo_empty, fifo_rd;
    logic [ENTRY_W-1:0]   fifo_rdata [CH_NUM];
    logic [CH_W-1:0]      rr_ptr_q, grant;
    logic                 any_req, load;
    logic                 out_valid_q;
    logic [OUT_WIDTH-1:0] out_data_q, out_word;

    for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
        logic [ENTRY_W-1:0]    wdata;
        logic                  overflow_q;
        logic [DROP_CNT_W-1:0] drop_cnt_q;

`ifdef TRACE_PACKER_TIMESTAMP_EN
        assign wdata = {ts_q, bus.in_data[i*DATA_WIDTH +: DATA_WIDTH]};
`else
        assign wdata = bus.in_data[i*DATA_WIDTH +: DATA_WIDTH];
`endif
        assign fifo_rd[i] = load && (grant == CH_W'(i));

        trace_fifo #(
            .WIDTH (ENTRY_W),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .wr_en (bus.in_valid[i]),
            .wdata (wdata),
            .rd_en (fifo_rd[i]),
            .rdata (fifo_rdata[i]),
            .full  (fifo_full[i]),
            .empty (fifo_empty[i])
        );

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                overflow_q <= 1'b0;
                drop_cnt_q <= '0;
            end else if (bus.in_valid[i] && fifo_full[i]) begin
                overflow_q <= 1'b1;
                if (drop_cnt_q != DROP_CNT_MAX) drop_cnt_q <= drop_cnt_q + 1'b1;
            end
        end

        assign bus.overflow[i]                            = overflow_q;
        assign bus.drop_cnt[i*DROP_CNT_W +: DROP_CNT_W] = drop_cnt_q;
    end

    // First non-empty channel after the last grant, wrapping at CH_NUM.
    always_comb begin
        logic [CH_W-1:0] cand;
        cand    = '0;
        grant   = rr_ptr_q;
        any_req = 1'b0;
        for (int unsigned k = 1; k <= CH_NUM; k++) begin
            cand = CH_W'((32'(rr_ptr_q) + k) % CH_NUM);
            if (!any_req && !fifo_empty[cand]) begin
                any_req = 1'b1;
                grant   = cand;
            end
        end
    end

    assign load = (!out_valid_q || bus.out_ready) && any_req;

`ifdef TRACE_PACKER_TIMESTAMP_EN
    assign out_word = {fifo_rdata[grant][DATA_WIDTH +: TS_WIDTH], grant,
                       fifo_rdata[grant][DATA_WIDTH-1:0]};
`else
    assign out_word = {grant, fifo_rdata[grant][DATA_WIDTH-1:0]};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            rr_ptr_q    <= CH_W'(CH_NUM - 1);
        end else if (load) begin
            out_valid_q <= 1'b1;
            out_data_q  <= out_word;
            rr_ptr_q    <= grant;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;

endmodule

// File: tb/tb_trace_packer.sv
// Scoreboard bench for trace_packer: per-channel expected queues, popped on each transfer.
// Honours TRACE_PACKER_TIMESTAMP_EN when defined for the whole build.
module tb_trace_packer;
    import trace_packer_pkg::*;

    localparam int unsigned CH_NUM     = 4;
    localparam int unsigned DATA_WIDTH = 64;
    localparam int unsigned FIFO_DEPTH = 8;
    localparam int unsigned TS_WIDTH   = 32;
    localparam int unsigned CH_W       = calc_ch_w(CH_NUM);
    localparam int unsigned OUT_W      = calc_out_width(CH_NUM, DATA_WIDTH, TS_WIDTH);

    logic clk = 1'b0;
    logic rst = 1'b1;

    trace_packer_if #(
        .CH_NUM     (CH_NUM),
        .DATA_WIDTH (DATA_WIDTH),
        .TS_WIDTH   (TS_WIDTH)
    ) bus ();

    trace_packer #(
        .CH_NUM     (CH_NUM),
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH),
        .TS_WIDTH   (TS_WIDTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int n_rx    = 0;

    logic [OUT_W-1:0]    sb_q [CH_NUM][$];
    int unsigned         got_ch[$];
    logic [OUT_W-1:0]    got_word[$];
    logic [TS_WIDTH-1:0] tb_ts;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference capture counter: value at an edge is the stamp of a sample taken there.
    always @(posedge clk or posedge rst) begin
        if (rst) tb_ts <= '0;
        else     tb_ts <= tb_ts + 1'b1;
    end

    function automatic logic [OUT_W-1:0] exp_word(input int unsigned ch,
                                                  input logic [DATA_WIDTH-1:0] d);
`ifdef TRACE_PACKER_TIMESTAMP_EN
        return {tb_ts, CH_W'(ch), d};
`else
        return {CH_W'(ch), d};
`endif
    endfunction

    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin : mon
            int unsigned ch;
            ch = int'(bus.out_data[DATA_WIDTH +: CH_W]);
            n_rx++;
            got_ch.push_back(ch);
            got_word.push_back(bus.out_data);
            check_eq("sb_has_entry", sb_q[ch].size() != 0, 1'b1);
            if (sb_q[ch].size() != 0) check_eq("sb_word", bus.out_data, sb_q[ch].pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.in_valid  = '0;
        bus.out_ready = 1'b0;
        for (int c = 0; c < CH_NUM; c++) sb_q[c].delete();
        got_ch.delete();
        got_word.delete();
        repeat (2) tick();
        rst = 1'b0;
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int pending;
        pending = 0;
        for (int n = 0; n < budget; n++) begin
            pending = 0;
            for (int c = 0; c < CH_NUM; c++) pending += sb_q[c].size();
            if (pending == 0) break;
            tick();
        end
        check_eq({tag, "_drain"}, pending, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rx0;
        bus.in_valid  = '0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;

        // Reset state
        do_reset();
        check_eq("rst_out_valid", bus.out_valid, 0);
        check_eq("rst_out_data", bus.out_data, 0);
        check_eq("rst_overflow", bus.overflow, 0);
        check_eq("rst_drop_cnt", bus.drop_cnt, 0);

        // Single sample on ch1: one edge of latency, one cycle of valid
        bus.out_ready = 1'b1;
        bus.in_valid[1] = 1'b1;
        bus.in_data[1*DATA_WIDTH +: DATA_WIDTH] = 64'hDEAD;
        sb_q[1].push_back(exp_word(1, 64'hDEAD));
        tick();
        bus.in_valid = '0;
        check_eq("single_not_yet", bus.out_valid, 0);
        tick();
        check_eq("single_valid", bus.out_valid, 1);
        check_eq("single_ch", bus.out_data[DATA_WIDTH +: CH_W], 1);
        check_eq("single_payload", bus.out_data[DATA_WIDTH-1:0], 64'hDEAD);
        tick();
        check_eq("single_one_cycle", bus.out_valid, 0);

        // Fairness: all channels every cycle for 8 cycles
        do_reset();
        bus.out_ready = 1'b1;
        for (int cyc = 0; cyc < 8; cyc++) begin
            for (int c = 0; c < CH_NUM; c++) begin
                bus.in_valid[c] = 1'b1;
                bus.in_data[c*DATA_WIDTH +: DATA_WIDTH] = 64'(c * 256 + cyc);
                sb_q[c].push_back(exp_word(c, 64'(c * 256 + cyc)));
            end
            tick();
        end
        bus.in_valid = '0;
        wait_drain("fair", 100);
        check_eq("fair_count", got_ch.size(), 32);
        for (int i = 0; i < got_ch.size(); i++) check_eq("fair_order", got_ch[i], i % CH_NUM);
        check_eq("fair_no_overflow", bus.overflow, 0);

        // Back-pressure: ch0 streams 0..19 with the sink stalled
        do_reset();
        rx0 = n_rx;
        for (int k = 0; k < 20; k++) begin
            bus.in_valid[0] = 1'b1;
            bus.in_data[0 +: DATA_WIDTH] = 64'(k);
            if (k <= FIFO_DEPTH) sb_q[0].push_back(exp_word(0, 64'(k)));
            tick();
        end
        bus.in_valid = '0;
        check_eq("bp_valid_held", bus.out_valid, 1);
        check_eq("bp_word0", bus.out_data[DATA_WIDTH-1:0], 0);
        check_eq("bp_drop_cnt0", bus.drop_cnt[0 +: DROP_CNT_W], 11);
        check_eq("bp_overflow", bus.overflow, 4'b0001);
        repeat (3) tick();
        check_eq("bp_frozen", bus.out_data[DATA_WIDTH-1:0], 0);
        bus.out_ready = 1'b1;
        wait_drain("bp", 50);
        check_eq("bp_rx_count", n_rx - rx0, 9);

        // Saturation of the ch2 drop counter
        do_reset();
        bus.in_valid[2] = 1'b1;
        repeat (FIFO_DEPTH + 1 + 100) tick();
        check_eq("sat_mid_count", bus.drop_cnt[2*DROP_CNT_W +: DROP_CNT_W], 100);
        repeat (65445) tick();
        bus.in_valid = '0;
        check_eq("sat_max", bus.drop_cnt[2*DROP_CNT_W +: DROP_CNT_W], 16'hFFFF);
        check_eq("sat_overflow", bus.overflow, 4'b0100);

        // Asynchronous reset mid-burst
        do_reset();
        for (int k = 0; k < 14; k++) begin
            bus.in_valid[1] = 1'b1;
            bus.in_data[1*DATA_WIDTH +: DATA_WIDTH] = 64'(100 + k);
            tick();
        end
        bus.in_valid = '0;
        check_eq("mid_valid_before", bus.out_valid, 1);
        check_eq("mid_drops_before", bus.drop_cnt[1*DROP_CNT_W +: DROP_CNT_W], 5);
        #3;
        rst = 1'b1;
        #1;
        check_eq("mid_async_valid", bus.out_valid, 0);
        check_eq("mid_async_data", bus.out_data, 0);
        check_eq("mid_async_drops", bus.drop_cnt, 0);
        check_eq("mid_async_overflow", bus.overflow, 0);
        for (int c = 0; c < CH_NUM; c++) sb_q[c].delete();
        repeat (2) tick();
        rst = 1'b0;
        bus.out_ready = 1'b1;
        rx0 = n_rx;
        repeat (20) tick();
        check_eq("mid_no_stale", n_rx - rx0, 0);
        check_eq("mid_idle_valid", bus.out_valid, 0);

`ifdef TRACE_PACKER_TIMESTAMP_EN
        // Two ch3 samples four cycles apart carry stamps four apart
        do_reset();
        bus.out_ready = 1'b1;
        repeat (4) tick();
        bus.in_valid[3] = 1'b1;
        bus.in_data[3*DATA_WIDTH +: DATA_WIDTH] = 64'hA5;
        sb_q[3].push_back(exp_word(3, 64'hA5));
        tick();
        bus.in_valid = '0;
        repeat (3) tick();
        bus.in_valid[3] = 1'b1;
        bus.in_data[3*DATA_WIDTH +: DATA_WIDTH] = 64'h5A;
        sb_q[3].push_back(exp_word(3, 64'h5A));
        tick();
        bus.in_valid = '0;
        wait_drain("ts", 20);
        check_eq("ts_count", got_word.size(), 2);
        if (got_word.size() == 2)
            check_eq("ts_delta", TS_WIDTH'(got_word[1][OUT_W-1 -: TS_WIDTH]
                                         - got_word[0][OUT_W-1 -: TS_WIDTH]), 4);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
